maze_map_memory: RTL and testbench
==================================

# maze_map_memory

Memory-side responder and host front end for the maze router. Owns the 256×8 map RAM that the router reads the maze from and writes the routed grid back to. The host loads the map through a valid/ready port while the router is held in reset, then pulses `go`. The block serves router read/write cycles with fixed 1-cycle read latency, detects the router's done flag, and streams the 64 result cells back to the host.

## Interface
- `ADDR_WIDTH`, 8, map RAM address width (256 entries)
- `DATA_WIDTH`, 8, map cell width
- `GRID_CELLS`, 64, result cells streamed back (addresses 0..GRID_CELLS-1)
- `TIMEOUT`, 4096, maximum RUN cycles before abort
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `load_valid`  in  1  host write request
- `load_ready`  out  1  host write accepted when both high
- `load_addr`  in  ADDR_WIDTH  host write address
- `load_data`  in  DATA_WIDTH  host write data
- `go`  in  1  start routing (sampled in LOAD only)
- `rt_reset`  out  1  drives router `reset`; high except in RUN
- `rt_start`  out  1  drives router `start`; one-cycle pulse on entering RUN
- `rt_address`  in  ADDR_WIDTH  router `address`
- `rt_cs`  in  1  router `cs`
- `rt_we`  in  1  router `we` (1 = write)
- `rt_wdata`  in  DATA_WIDTH  router `data_out`
- `rt_rdata`  out  DATA_WIDTH  to router `data_in`
- `rt_done`  in  1  router `D`
- `res_valid`  out  1  result cell valid
- `res_ready`  in  1  host accepts result cell
- `res_data`  out  DATA_WIDTH  result cell (0x00 = routed path, 0xEE = free, others unchanged)
- `res_index`  out  6  cell index 0..63
- `res_last`  out  1  high with index 63
- `busy`  out  1  state != LOAD
- `done`  out  1  one-cycle pulse after last result accepted
- `error`  out  1  sticky timeout flag, cleared by accepted `go`

## Operation
- Map layout: 0x00–0x3F grid (row-major 8×8, 0xEE free, other values blocked); 0x80 source index; 0x81 target index.
- States: LOAD → RUN → DRAIN → LOAD.
- LOAD: `load_ready`=1, `rt_reset`=1. Write `mem[load_addr]<=load_data` on `load_valid&&load_ready`. `go`=1 → RUN and clear `error`; a simultaneous host write still completes.
- RUN: `load_ready`=0, `rt_reset`=0, `rt_start` pulses in the first RUN cycle. On `rt_cs&&rt_we`, write `mem[rt_address]<=rt_wdata`. On `rt_cs&&!rt_we`, `rt_rdata<=mem[rt_address]` (registered). The cycle counter increments each RUN cycle.
  - `rt_done`=1 → DRAIN. All router writes are already committed, because the router raises D on the edge after its last write is presented.
  - Counter reaches TIMEOUT-1 without `rt_done` → `error`<=1, then DRAIN.
- DRAIN: `rt_reset`=1 and router ports are ignored. The read pointer runs 0..63. At most one read is outstanding: a read is issued when no read is pending and `res_valid`=0, or when the current cell is being accepted. `res_valid` rises the cycle after issue. A handshake on index 63 → `done` pulse, then LOAD.
- Router ports are ignored outside RUN. `go` is ignored outside LOAD. Host writes stall (`load_ready`=0) outside LOAD.
- RAM contents are not cleared by reset and persist across runs.

## Timing
- Reset values: state LOAD, `load_ready`=1, `rt_reset`=1, `rt_start`=0, `rt_rdata`=0, `res_valid`=0, `res_data`=0, `res_index`=0, `res_last`=0, `busy`=0, `done`=0, `error`=0, counters 0.
- Router read latency is exactly 1 cycle. The address presented after edge k is returned on `rt_rdata` after edge k+1 and is sampled by the router at edge k+2. Ordering from the router side: `mem[n]` lands in router cell n-2 of its count.
- A router write presented after edge k is committed at edge k+1. A read of the same address at that edge returns the old data.
- `go` at edge k → RUN after k. `rt_reset` is low and `rt_start` is high in cycle k+1.
- `rt_done` sampled at edge k → DRAIN after k. First `res_valid` no earlier than 2 cycles later.
- `res_data`/`res_index`/`res_last` hold stable while `res_valid&&!res_ready`.
- Reset mid-RUN or mid-DRAIN → LOAD next cycle. The stream is abandoned and the router is held in reset.

## Test plan
- Load an open 8×8 grid (all 0xEE), source 0x00, target 0x07, `go`. Stub router echoes reads and writes 0x00 to cells 0..7 → stream returns 0x00 for indices 0–7, 0xEE for 8–63, `res_last` at 63, `done` pulse, `error`=0.
- Read latency: router reads addresses 0x10, 0x11, 0x80 back-to-back → `rt_rdata` shows `mem[0x10]`, `mem[0x11]`, `mem[0x80]` one cycle after each address.
- Backpressure: `res_ready` toggling 1-0-0-1 during DRAIN → no cell dropped or duplicated, indices strictly 0..63, data stable while stalled.
- Timeout: TIMEOUT=32 and stub never asserts `rt_done` → `error`=1 after 32 RUN cycles, DRAIN still streams 64 cells, next `go` clears `error`.
- `load_valid` held high through RUN → `load_ready`=0, no RAM change. `go` in RUN ignored.
- `reset` asserted at DRAIN index 20 → LOAD next cycle, `res_valid`=0, `rt_reset`=1. RAM contents retained, so a fresh `go` reproduces an identical stream.

Source files
------------

// File: rtl/maze_map_memory.sv
// Map RAM and host front end for the maze router: host loads the map, the router
// runs against the RAM, then the 64 grid cells are streamed back with valid/ready.
module maze_map_memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int GRID_CELLS = 64,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  go,
    output logic                  rt_reset,
    output logic                  rt_start,
    input  logic [ADDR_WIDTH-1:0] rt_address,
    input  logic                  rt_cs,
    input  logic                  rt_we,
    input  logic [DATA_WIDTH-1:0] rt_wdata,
    output logic [DATA_WIDTH-1:0] rt_rdata,
    input  logic                  rt_done,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [5:0]            res_index,
    output logic                  res_last,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int              CW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   LP_TLAST  = CW'(TIMEOUT - 1);
    localparam logic [6:0]      LP_CELLS  = 7'(GRID_CELLS);
    localparam logic [6:0]      LP_LASTIX = 7'(GRID_CELLS - 1);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [CW-1:0]         r_cnt;
    logic [6:0]            r_rptr;
    logic                  r_rt_start, r_res_valid, r_res_last, r_done, r_error;
    logic [DATA_WIDTH-1:0] r_rt_rdata, r_res_data;
    logic [5:0]            r_res_index;

    logic                  w_host_wr, w_rt_wr, w_rt_rd, w_go, w_timeout;
    logic                  w_issue, w_accept, w_mem_we;
    logic [ADDR_WIDTH-1:0] w_waddr, w_draddr;
    logic [DATA_WIDTH-1:0] w_wdata;

    always_comb begin
        w_host_wr = (r_state == S_LOAD) && load_valid;
        w_go      = (r_state == S_LOAD) && go;
        w_rt_wr   = (r_state == S_RUN) && rt_cs && rt_we;
        w_rt_rd   = (r_state == S_RUN) && rt_cs && !rt_we;
        w_timeout = (r_state == S_RUN) && !rt_done && (r_cnt == LP_TLAST);
        // Single outstanding read: refill only when the output slot is empty or draining
        w_issue   = (r_state == S_DRAIN) && (r_rptr < LP_CELLS) && (!r_res_valid || res_ready);
        w_accept  = (r_state == S_DRAIN) && r_res_valid && res_ready;
        w_mem_we  = w_host_wr || w_rt_wr;
        w_waddr   = w_host_wr ? load_addr : rt_address;
        w_wdata   = w_host_wr ? load_data : rt_wdata;
        w_draddr  = ADDR_WIDTH'(r_rptr[5:0]);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (go) w_next = S_RUN;
            S_RUN:   if (rt_done || w_timeout) w_next = S_DRAIN;
            S_DRAIN: if (w_accept && r_res_last) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_LOAD;
        else       r_state <= w_next;
    end

    // RAM is deliberately outside reset so the map survives across runs
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rptr      <= '0;
            r_rt_start  <= 1'b0;
            r_rt_rdata  <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_index <= '0;
            r_res_last  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_rt_start <= w_go;
            r_done     <= w_accept && r_res_last;
            if (w_go)           r_error <= 1'b0;
            else if (w_timeout) r_error <= 1'b1;
            r_cnt <= (r_state == S_RUN) ? r_cnt + 1'b1 : '0;
            if (w_rt_rd) r_rt_rdata <= r_mem[rt_address];
            if (r_state != S_DRAIN) r_rptr <= '0;
            else if (w_issue)       r_rptr <= r_rptr + 1'b1;
            if (w_issue) begin
                r_res_valid <= 1'b1;
                r_res_data  <= r_mem[w_draddr];
                r_res_index <= r_rptr[5:0];
                r_res_last  <= (r_rptr == LP_LASTIX);
            end else if (w_accept) begin
                r_res_valid <= 1'b0;
                r_res_last  <= 1'b0;
            end
        end
    end

    assign load_ready = (r_state == S_LOAD);
    assign rt_reset   = (r_state != S_RUN);
    assign busy       = (r_state != S_LOAD);
    assign rt_start   = r_rt_start;
    assign rt_rdata   = r_rt_rdata;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_index  = r_res_index;
    assign res_last   = r_res_last;
    assign done       = r_done;
    assign error      = r_error;
endmodule

// File: tb/tb_maze_map_memory.sv
// Bench for maze_map_memory: a byte-array model of the map RAM predicts router reads
// and the result stream; router and host are driven by tasks.
module tb_maze_map_memory;
    logic       clk = 0;
    logic       reset = 1;
    logic       load_valid = 0, go = 0;
    logic [7:0] load_addr = 0, load_data = 0;
    logic       load_ready, rt_reset, rt_start;
    logic [7:0] rt_address = 0, rt_wdata = 0, rt_rdata;
    logic       rt_cs = 0, rt_we = 0, rt_done = 0;
    logic       res_valid, res_ready = 0, res_last, busy, done, error;
    logic [7:0] res_data;
    logic [5:0] res_index;

    logic [7:0] ref_mem [256];
    int n_chk = 0, n_pass = 0;

    maze_map_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .GRID_CELLS(64), .TIMEOUT(32)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data), .go(go), .rt_reset(rt_reset),
        .rt_start(rt_start), .rt_address(rt_address), .rt_cs(rt_cs), .rt_we(rt_we),
        .rt_wdata(rt_wdata), .rt_rdata(rt_rdata), .rt_done(rt_done), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_index(res_index), .res_last(res_last),
        .busy(busy), .done(done), .error(error));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d, input bit with_go);
        int t = 0;
        load_valid = 1; load_addr = a; load_data = d; go = with_go;
        while (!load_ready && t < 50) begin tick(); t++; end
        n_chk++; if (load_ready !== 1'b1) $display("FAIL host_write_stall addr=%h load_ready=%b exp=1", a, load_ready); else n_pass++;
        tick();
        load_valid = 0; go = 0;
        ref_mem[a] = d;
    endtask

    task automatic load_map(input bit open_grid);
        for (int i = 0; i < 64; i++)
            host_write(8'(i), open_grid ? 8'hEE : (($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hEE), 0);
        host_write(8'h80, 8'($urandom_range(0, 63)), 0);
        host_write(8'h81, 8'($urandom_range(0, 63)), 0);
    endtask

    task automatic start_run();
        go = 1; tick(); go = 0;
        n_chk++; if ({rt_reset, rt_start, busy, load_ready, error} !== 5'b01100)
            $display("FAIL go_entry got={rst,start,busy,ldrdy,err}=%b exp=01100", {rt_reset, rt_start, busy, load_ready, error}); else n_pass++;
    endtask

    task automatic rt_op(input bit we, input logic [7:0] a, input logic [7:0] d);
        rt_cs = 1; rt_we = we; rt_address = a; rt_wdata = d;
        tick();
        rt_cs = 0; rt_we = 0;
        if (we) ref_mem[a] = d;
    endtask

    task automatic finish_run();
        rt_done = 1; tick(); rt_done = 0;
        n_chk++; if ({busy, rt_reset, res_valid} !== 3'b110)
            $display("FAIL drain_entry got={busy,rst,vld}=%b exp=110", {busy, rt_reset, res_valid}); else n_pass++;
    endtask

    // mode 0: always ready, 1: ready pattern 1-0-0-1, 2: random ready
    task automatic drain(input int mode, input bit exp_err, input int stop_at, input bit junk);
        int idx = 0, cyc = 0;
        bit stalled = 0, stop = 0;
        logic [7:0] hd = 0;
        logic [5:0] hi = 0;
        while (idx < 64 && !stop && cyc < 1000) begin
            if (junk) begin rt_cs = 1; rt_we = 1; rt_address = 8'($urandom); rt_wdata = 8'($urandom); end
            case (mode)
                0:       res_ready = 1;
                1:       res_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
            if (stalled) begin
                n_chk++; if ({res_valid, res_data, res_index} !== {1'b1, hd, hi})
                    $display("FAIL stall_hold got=%b/%h/%0d exp=1/%h/%0d", res_valid, res_data, res_index, hd, hi); else n_pass++;
            end
            if (res_valid && stop_at >= 0 && int'(res_index) == stop_at) begin
                res_ready = 0; stop = 1;
            end else begin
                n_chk++; if (done !== 1'b0) $display("FAIL early_done got=%b exp=0 at cell %0d", done, idx); else n_pass++;
                if (res_valid && res_ready) begin
                    n_chk++; if ({res_index, res_data, res_last} !== {6'(idx), ref_mem[idx], idx == 63})
                        $display("FAIL cell got=%0d/%h/%b exp=%0d/%h/%b", res_index, res_data, res_last, idx, ref_mem[idx], idx == 63); else n_pass++;
                    idx++; stalled = 0;
                end else if (res_valid) begin
                    stalled = 1; hd = res_data; hi = res_index;
                end
                tick(); cyc++;
            end
        end
        rt_cs = 0; rt_we = 0;
        if (stop) return;
        n_chk++; if (idx != 64) $display("FAIL drain_budget got %0d cells exp 64", idx); else n_pass++;
        n_chk++; if ({done, busy, res_valid, load_ready, error} !== {4'b1001, exp_err})
            $display("FAIL drain_end got={done,busy,vld,ldrdy,err}=%b exp=1001%b", {done, busy, res_valid, load_ready, error}, exp_err); else n_pass++;
        res_ready = 0;
        tick();
        n_chk++; if (done !== 1'b0) $display("FAIL done_pulse got=%b exp=0", done); else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1; tick(); tick(); tick();
        n_chk++; if ({load_ready, rt_reset, rt_start, res_valid, res_last, busy, done, error} !== 8'b11000000)
            $display("FAIL reset_flags got=%b exp=11000000", {load_ready, rt_reset, rt_start, res_valid, res_last, busy, done, error}); else n_pass++;
        n_chk++; if ({rt_rdata, res_data, res_index} !== 22'd0)
            $display("FAIL reset_data got=%h/%h/%0d exp=0/0/0", rt_rdata, res_data, res_index); else n_pass++;
        reset = 0; tick();
    endtask

    task automatic test_open_grid();
        load_map(1);
        host_write(8'h80, 8'h00, 0);
        host_write(8'h81, 8'h07, 1);  // target written in the same cycle as go
        n_chk++; if ({rt_reset, rt_start, busy, load_ready, error} !== 5'b01100)
            $display("FAIL go_with_write got=%b exp=01100", {rt_reset, rt_start, busy, load_ready, error}); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            rt_op(1, 8'(i), 8'h00);
            if (i == 0) begin
                n_chk++; if (rt_start !== 1'b0) $display("FAIL start_pulse got=%b exp=0", rt_start); else n_pass++;
            end
        end
        rt_cs = 1; rt_we = 0; rt_address = 8'h81; tick(); rt_cs = 0;
        n_chk++; if (rt_rdata !== 8'h07) $display("FAIL target_read got=%h exp=07", rt_rdata); else n_pass++;
        finish_run();
        drain(0, 0, -1, 0);
    endtask

    task automatic test_read_latency();
        logic [7:0] seq [3];
        logic [7:0] a, d, old10;
        seq[0] = 8'h10; seq[1] = 8'h11; seq[2] = 8'h80;
        load_map(0);
        old10 = ref_mem[8'h10];
        start_run();
        load_valid = 1; load_addr = 8'h10; load_data = ~old10; go = 1;  // must both be ignored in RUN
        for (int i = 0; i < 3; i++) begin
            rt_cs = 1; rt_we = 0; rt_address = seq[i]; tick();
            n_chk++; if ({rt_rdata, load_ready, busy} !== {ref_mem[seq[i]], 2'b01})
                $display("FAIL read_b2b[%0d] got=%h/%b/%b exp=%h/0/1", i, rt_rdata, load_ready, busy, ref_mem[seq[i]]); else n_pass++;
        end
        rt_cs = 0;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom_range(0, 63)); d = 8'($urandom);
            rt_op(1, a, d);
            rt_cs = 1; rt_we = 0; rt_address = a; tick(); rt_cs = 0;
            n_chk++; if (rt_rdata !== d) $display("FAIL write_then_read addr=%h got=%h exp=%h", a, rt_rdata, d); else n_pass++;
        end
        load_valid = 0; go = 0;
        finish_run();
        drain(1, 0, -1, 0);
    endtask

    task automatic test_timeout();
        load_map(0);
        start_run();
        for (int i = 1; i < 32; i++) tick();
        n_chk++; if ({rt_reset, error, busy} !== 3'b001)
            $display("FAIL timeout_early got={rst,err,busy}=%b exp=001", {rt_reset, error, busy}); else n_pass++;
        tick();
        n_chk++; if ({rt_reset, busy, error, res_valid} !== 4'b1110)
            $display("FAIL timeout_err got={rst,busy,err,vld}=%b exp=1110", {rt_reset, busy, error, res_valid}); else n_pass++;
        drain(2, 1, -1, 1);
        start_run();  // accepted go clears the sticky error
        for (int i = 0; i < 4; i++) rt_op(1, 8'($urandom_range(0, 63)), 8'($urandom));
        finish_run();
        drain(0, 0, -1, 0);
    endtask

    task automatic test_reset_mid_drain();
        start_run();
        for (int i = 0; i < 3; i++) rt_op(1, 8'($urandom_range(0, 63)), 8'h00);
        finish_run();
        drain(2, 0, 20, 1);
        n_chk++; if ({res_valid, res_index} !== {1'b1, 6'd20})
            $display("FAIL stop_at_20 got=%b/%0d exp=1/20", res_valid, res_index); else n_pass++;
        reset = 1; tick(); reset = 0;
        n_chk++; if ({res_valid, rt_reset, busy, load_ready, done} !== 5'b01010)
            $display("FAIL mid_drain_reset got={vld,rst,busy,ldrdy,done}=%b exp=01010", {res_valid, rt_reset, busy, load_ready, done}); else n_pass++;
        tick();
        start_run();
        finish_run();
        drain(2, 0, -1, 0);
    endtask

    initial begin
        test_reset();
        test_open_grid();
        test_read_latency();
        test_timeout();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
